// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with a Moore-style registered match
// pulse and a saturating match counter.
module seq_det_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0001_0110),
  parameter int                 DEF_LEN = 5,
  parameter bit                 DEF_OVL = 1'b1,
  localparam int                LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_en,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic               r_y;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;

  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LW-1:0]      w_fill_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_nxt;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    return (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Candidate shift, fill and match decision for the current input bit
  always_comb begin
    w_hist_nxt = {r_hist[MAX_LEN-2:0], x};
    w_fill_nxt = (r_fill >= LW'(MAX_LEN)) ? r_fill : r_fill + LW'(1);
    w_mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    w_hit = in_en && !cfg_load && (r_len != '0) && (w_fill_nxt >= r_len) &&
            ((w_hist_nxt & w_mask) == (r_pat & w_mask));
    if (cnt_clr)    w_cnt_nxt = '0;
    else if (w_hit) w_cnt_nxt = sat_inc(r_cnt);
    else            w_cnt_nxt = r_cnt;
  end

  // Configuration, history and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pat  <= DEF_PAT;
      r_len  <= LW'(DEF_LEN);
      r_ovl  <= DEF_OVL;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_pat  <= cfg_pattern;
        r_len  <= clamp_len(cfg_len);
        r_ovl  <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
        r_y    <= 1'b0;
      end else if (in_en) begin
        r_y <= w_hit;
        // Non-overlapping mode forgets every bit of a detected match
        if (w_hit && !r_ovl) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_hist_nxt;
          r_fill <= w_fill_nxt;
        end
      end else begin
        r_y <= 1'b0;
      end
      r_cnt <= w_cnt_nxt;
      r_sat <= &w_cnt_nxt;
    end
  end

  assign y         = r_y;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param (MAX_LEN=8, CNT_W=2) with hand-computed expectations.
module tb_seq_det_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_en = 1'b0;
  logic               x = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  int n_chk  = 0;
  int n_pass = 0;

  seq_det_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_en(in_en), .x(x),
    .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic send(input logic b, input logic clr);
    @(negedge clk);
    rst = 1'b1; cfg_load = 1'b0; in_en = 1'b1; x = b; cnt_clr = clr;
    @(posedge clk); #1;
    in_en = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic stream(input logic [15:0] bits, input int n, output logic [15:0] ys);
    ys = '0;
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], 1'b0);
      ys = {ys[14:0], y};
    end
  endtask

  task automatic idle(input int n, input logic clr, output logic [15:0] ys);
    ys = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; cfg_load = 1'b0; in_en = 1'b0; x = ~x; cnt_clr = clr;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      ys = {ys[14:0], y};
    end
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len,
                      input logic ovl);
    @(negedge clk);
    rst = 1'b1; cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_en = 1'b1; x = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; in_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  logic [15:0] ys;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);

    // default pattern 10110
    stream(16'b10110, 5, ys);
    chk("dflt_y", 32'(ys), 32'h01);
    chk("dflt_cnt", 32'(match_cnt), 32'd1);
    idle(1, 1'b0, ys);
    chk("dflt_y_drop", 32'(ys), 32'd0);

    // overlap, then non-overlap replay
    do_reset();
    stream(16'b10110110, 8, ys);
    chk("ovl_y", 32'(ys), 32'h09);
    chk("ovl_cnt", 32'(match_cnt), 32'd2);
    load(8'b0001_0110, 4'd5, 1'b0);
    chk("load_y", 32'(y), 32'd0);
    stream(16'b10110110, 8, ys);
    chk("novl_y", 32'(ys), 32'h08);
    chk("novl_cnt", 32'(match_cnt), 32'd3);
    chk("novl_sat", 32'(cnt_sat), 32'd1);

    // stall mid-pattern
    do_reset();
    stream(16'b101, 3, ys);
    chk("stall_pre_y", 32'(ys), 32'd0);
    idle(3, 1'b0, ys);
    chk("stall_idle_y", 32'(ys), 32'd0);
    stream(16'b10, 2, ys);
    chk("stall_post_y", 32'(ys), 32'h1);
    chk("stall_cnt", 32'(match_cnt), 32'd1);

    // reprogram mid-stream; the load-cycle x is discarded
    stream(16'b10, 2, ys);
    load(8'b1100_1010, 4'd8, 1'b1);
    stream(16'hCA, 8, ys);
    chk("reprog_y", 32'(ys), 32'h01);
    chk("reprog_cnt", 32'(match_cnt), 32'd2);

    // len=0 disables detection
    load(8'b1100_1010, 4'd0, 1'b1);
    stream(16'hFFFF, 16, ys);
    chk("len0_ones_y", 32'(ys), 32'd0);
    stream(16'hCACA, 16, ys);
    chk("len0_pat_y", 32'(ys), 32'd0);
    chk("len0_cnt", 32'(match_cnt), 32'd2);

    // cfg_len=15 clamps to 8
    load(8'b1100_1010, 4'd15, 1'b1);
    stream(16'hCACA, 16, ys);
    chk("clamp_y", 32'(ys), 32'h0101);
    chk("clamp_cnt", 32'(match_cnt), 32'd3);
    chk("clamp_sat", 32'(cnt_sat), 32'd1);

    // counter saturation and clear priority
    idle(1, 1'b1, ys);
    chk("clr_cnt", 32'(match_cnt), 32'd0);
    chk("clr_sat", 32'(cnt_sat), 32'd0);
    load(8'b0000_0001, 4'd1, 1'b1);
    stream(16'b1111, 4, ys);
    chk("b2b_y", 32'(ys), 32'hF);
    chk("sat_cnt", 32'(match_cnt), 32'd3);
    chk("sat_sat", 32'(cnt_sat), 32'd1);
    send(1'b1, 1'b0);
    chk("sat_hold_y", 32'(y), 32'd1);
    chk("sat_hold_cnt", 32'(match_cnt), 32'd3);
    send(1'b1, 1'b1);
    chk("clr_hit_y", 32'(y), 32'd1);
    chk("clr_hit_cnt", 32'(match_cnt), 32'd0);
    chk("clr_hit_sat", 32'(cnt_sat), 32'd0);

    // reset in the middle of a match restores defaults
    do_reset();
    stream(16'b1011, 4, ys);
    do_reset();
    chk("mid_rst_y", 32'(y), 32'd0);
    send(1'b0, 1'b0);
    chk("mid_rst_post_y", 32'(y), 32'd0);
    chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
    chk("mid_rst_sat", 32'(cnt_sat), 32'd0);
    stream(16'b10110110, 8, ys);
    chk("mid_rst_dflt_y", 32'(ys), 32'h09);
    chk("mid_rst_dflt_cnt", 32'(match_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
